interrupt_acknowledge_sequencer: RTL and testbench
==================================================

Name: interrupt_acknowledge_sequencer

Overview:
- Consumer side of the interrupt request register (IRR).
- Resolves the highest-priority unmasked pending request and raises INT to the CPU.
- Runs the 8086-mode two-pulse INTA sequence. On the first pulse it freezes the IRR, clears the acknowledged IRR bit, and sets the in-service bit. On the second pulse it drives the interrupt vector.
- Also handles non-specific EOI and auto-EOI. Sits between the IRR, the control/ICW registers and the data-bus buffer.

Parameters:
- SPURIOUS_LEVEL, 7, level reported when no request is pending at the first INTA.

Ports:
- clock  in  1  system clock, rising edge.
- write_initial_command_word_1_reset  in  1  asynchronous active-high reset.
- interrupt_request_register  in  8  IRR contents; bit 0 is highest priority.
- interrupt_mask  in  8  OCW1 mask; 1 = masked.
- interrupt_acknowledge_n  in  1  INTA#, already synchronised to clock, active low.
- end_of_interrupt  in  1  one-cycle non-specific EOI strobe.
- auto_eoi_config  in  1  ICW4 AEOI bit.
- vector_base  in  5  ICW2 T7..T3.
- interrupt_to_cpu  out  1  INT pin.
- freeze  out  1  to IRR; holds IRR while high.
- clear_interrupt_request  out  8  to IRR; one-hot, one-cycle pulse.
- in_service_register  out  8  ISR.
- data_bus_out  out  8  vector byte.
- data_bus_out_enable  out  1  drive enable for data_bus_out.

Behaviour:
- Reset value of every output and register is 0. State resets to IDLE; inta_prev resets to 1. Reset is effective in any state, including mid-sequence.
- pending = IRR & ~mask. p = lowest set index of pending. s = lowest set index of ISR (8 if ISR = 0).
- interrupt_to_cpu is registered. In IDLE: next = |pending && p < s. It forces 0 from the cycle after the first INTA falling edge until the sequence returns to IDLE.
- Edges: fall = inta_prev & ~interrupt_acknowledge_n; rise = ~inta_prev & interrupt_acknowledge_n. inta_prev is a register.
- State machine states: IDLE, ACK1, WAIT2, ACK2.
- IDLE -> ACK1 on fall. On that edge the selected level L (p if pending != 0, else SPURIOUS_LEVEL) is latched. The next cycle has these outputs:
  - freeze = 1.
  - If pending != 0: clear_interrupt_request = 1<<L for exactly one cycle, and ISR[L] is set.
  - If pending == 0 (spurious): no IRR clear and no ISR set.
- ACK1 -> WAIT2 on rise. WAIT2 -> ACK2 on fall.
- ACK2: data_bus_out = {vector_base, L[2:0]} and data_bus_out_enable = 1, starting the cycle after fall and held while in ACK2.
- ACK2 -> IDLE on rise. The next cycle: data_bus_out_enable = 0, data_bus_out = 0, freeze = 0. If auto_eoi_config = 1 and the request was not spurious, ISR[L] clears in that same cycle.
- A fall while in IDLE is the only sequence start. A stray rise in IDLE is ignored.
- EOI:
  - When end_of_interrupt is high, the lowest set ISR bit, taken as of the start of the cycle, clears in the next cycle. EOI with ISR = 0 has no effect.
  - If EOI coincides with an ISR set: the clear applies to the old ISR contents, and the new set also takes effect, in the same cycle.
- IRR changes during ACK1/WAIT2/ACK2 do not alter L.
- Masking L after the first INTA does not abort the sequence.

Decomposition:
- Shared package holds:
  - State encoding constants: IDLE=2'd0, ACK1=2'd1, WAIT2=2'd2, ACK2=2'd3.
  - Function for the lowest-set-bit index, returning 3-bit index plus valid.
  - Function for level-to-one-hot conversion.
- One natural sub-module: priority_resolver, which is combinational. It takes pending and ISR and returns p, a valid flag, and the request-higher-than-service flag. The same block is reused for the EOI target.

Test Plan:
- Reset mid-ACK2 with vector driving -> next cycle all outputs 0; a subsequent INTA sequence starts from IDLE.
- IRR=0x28, mask=0x00, ISR=0, vector_base=5'b00001 -> INT=1 one cycle later. On the first INTA: freeze=1, clear_interrupt_request=0x08 for one cycle, ISR=0x08. On the second INTA: data_bus_out=0x0B with enable=1. After the second rise: freeze=0, ISR stays 0x08 (AEOI=0).
- With ISR=0x08 and IRR=0x20 -> INT stays 0. IRR=0x04 -> INT=1. Acknowledge it -> ISR=0x0C. EOI pulse -> ISR=0x08. EOI again -> ISR=0x00.
- AEOI=1, IRR=0x80 -> full sequence gives vector {base,3'b111}. ISR is 0x80 during the sequence and 0x00 the cycle after the second rise.
- Spurious: IRR=0x02 raises INT, then IRR goes to 0x00 before the first INTA -> no clear pulse, ISR unchanged, vector {base,3'b111}.
- mask=0xFF with IRR=0xFF -> INT stays 0. EOI together with the first-INTA ISR set (ISR=0x01 and IRR=0x01 rejected) -> verify the old bit clears and the new bit sets in the same cycle.

Source files
------------

// File: rtl/interrupt_acknowledge_sequencer_pkg.sv
// Shared types and helpers for the interrupt acknowledge sequencer:
// FSM encoding, lowest-set-bit search and level decoding.
package interrupt_acknowledge_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACK1  = 2'd1,
        WAIT2 = 2'd2,
        ACK2  = 2'd3
    } ack_state_t;

    typedef struct packed {
        logic       valid;
        logic [2:0] index;
    } lowest_bit_t;

    // Bit 0 carries the highest priority, so the search returns the lowest set index.
    function automatic lowest_bit_t lowest_set_bit(input logic [7:0] bits);
        lowest_bit_t result;
        result = '0;
        for (int i = 7; i >= 0; i--) begin
            if (bits[i]) begin
                result.valid = 1'b1;
                result.index = 3'(i);
            end
        end
        return result;
    endfunction

    function automatic logic [7:0] level_to_one_hot(input logic [2:0] level);
        return 8'b0000_0001 << level;
    endfunction

endpackage

// File: rtl/interrupt_acknowledge_sequencer_priority_resolver.sv
// Combinational priority resolver: picks the highest-priority pending level
// and reports whether it outranks everything currently in service.
module priority_resolver
    import interrupt_acknowledge_sequencer_pkg::*;
(
    input  logic [7:0] pending,
    input  logic [7:0] in_service,
    output logic [2:0] level,
    output logic       valid,
    output logic       request_higher
);

    lowest_bit_t request_bit;
    lowest_bit_t service_bit;

    // An empty ISR behaves as level 8, below every real request.
    always_comb begin
        request_bit    = lowest_set_bit(pending);
        service_bit    = lowest_set_bit(in_service);
        level          = request_bit.index;
        valid          = request_bit.valid;
        request_higher = request_bit.valid &&
                         (!service_bit.valid || (request_bit.index < service_bit.index));
    end

endmodule

// File: rtl/interrupt_acknowledge_sequencer.sv
// 8086-mode INTA sequencer: raises INT, runs the two-pulse acknowledge,
// maintains the ISR (EOI / AEOI) and drives the vector byte.
module interrupt_acknowledge_sequencer
    import interrupt_acknowledge_sequencer_pkg::*;
#(
    parameter int unsigned SPURIOUS_LEVEL = 7
)
(
    input  logic       clock,
    input  logic       write_initial_command_word_1_reset,
    input  logic [7:0] interrupt_request_register,
    input  logic [7:0] interrupt_mask,
    input  logic       interrupt_acknowledge_n,
    input  logic       end_of_interrupt,
    input  logic       auto_eoi_config,
    input  logic [4:0] vector_base,
    output logic       interrupt_to_cpu,
    output logic       freeze,
    output logic [7:0] clear_interrupt_request,
    output logic [7:0] in_service_register,
    output logic [7:0] data_bus_out,
    output logic       data_bus_out_enable
);

    ack_state_t state, state_next;
    logic       inta_prev;
    logic [2:0] level, level_next;
    logic       spurious, spurious_next;
    logic       interrupt_next, freeze_next, enable_next;
    logic [7:0] clear_next, isr_next, data_next;

    logic [7:0] pending;
    logic [2:0] request_level, eoi_level;
    logic       request_valid, request_higher, eoi_valid, eoi_higher;
    logic       fall, rise;

    assign pending = interrupt_request_register & ~interrupt_mask;
    assign fall    = inta_prev & ~interrupt_acknowledge_n;
    assign rise    = ~inta_prev & interrupt_acknowledge_n;

    priority_resolver u_request_resolver (
        .pending        (pending),
        .in_service     (in_service_register),
        .level          (request_level),
        .valid          (request_valid),
        .request_higher (request_higher)
    );

    // With nothing in service the second resolver simply finds the lowest ISR bit.
    priority_resolver u_eoi_resolver (
        .pending        (in_service_register),
        .in_service     (8'h00),
        .level          (eoi_level),
        .valid          (eoi_valid),
        .request_higher (eoi_higher)
    );

    always_comb begin
        state_next     = state;
        level_next     = level;
        spurious_next  = spurious;
        interrupt_next = 1'b0;
        freeze_next    = freeze;
        clear_next     = 8'h00;
        data_next      = data_bus_out;
        enable_next    = data_bus_out_enable;
        isr_next       = in_service_register;

        // EOI acts on the ISR as it stood at the start of the cycle; a set below still lands.
        if (end_of_interrupt && eoi_valid && eoi_higher) begin
            isr_next = isr_next & ~level_to_one_hot(eoi_level);
        end

        case (state)
            IDLE: begin
                interrupt_next = request_higher;
                if (fall) begin
                    state_next     = ACK1;
                    interrupt_next = 1'b0;
                    freeze_next    = 1'b1;
                    level_next     = request_valid ? request_level : 3'(SPURIOUS_LEVEL);
                    spurious_next  = !request_valid;
                    if (request_valid) begin
                        clear_next = level_to_one_hot(request_level);
                        isr_next   = isr_next | clear_next;
                    end
                end
            end
            ACK1: begin
                if (rise) begin
                    state_next = WAIT2;
                end
            end
            WAIT2: begin
                if (fall) begin
                    state_next  = ACK2;
                    data_next   = {vector_base, level};
                    enable_next = 1'b1;
                end
            end
            ACK2: begin
                if (rise) begin
                    state_next  = IDLE;
                    data_next   = 8'h00;
                    enable_next = 1'b0;
                    freeze_next = 1'b0;
                    if (auto_eoi_config && !spurious) begin
                        isr_next = isr_next & ~level_to_one_hot(level);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge write_initial_command_word_1_reset) begin
        if (write_initial_command_word_1_reset) begin
            state                   <= IDLE;
            inta_prev               <= 1'b1;
            level                   <= 3'd0;
            spurious                <= 1'b0;
            interrupt_to_cpu        <= 1'b0;
            freeze                  <= 1'b0;
            clear_interrupt_request <= 8'h00;
            in_service_register     <= 8'h00;
            data_bus_out            <= 8'h00;
            data_bus_out_enable     <= 1'b0;
        end else begin
            state                   <= state_next;
            inta_prev               <= interrupt_acknowledge_n;
            level                   <= level_next;
            spurious                <= spurious_next;
            interrupt_to_cpu        <= interrupt_next;
            freeze                  <= freeze_next;
            clear_interrupt_request <= clear_next;
            in_service_register     <= isr_next;
            data_bus_out            <= data_next;
            data_bus_out_enable     <= enable_next;
        end
    end

endmodule

// File: tb/tb_interrupt_acknowledge_sequencer.sv
// Self-checking bench for interrupt_acknowledge_sequencer: directed vector table,
// hand-written corner sequences, then random traffic against a reference model.
module tb_interrupt_acknowledge_sequencer;

    logic       clock = 1'b0;
    logic       rst;
    logic [7:0] irr, mask;
    logic       inta_n, eoi, aeoi;
    logic [4:0] base;

    logic       int_cpu, freeze;
    logic [7:0] clear_req, isr, data_out;
    logic       data_en;

    int assertions = 0;
    int failures   = 0;

    typedef struct {
        logic [7:0] irr;
        logic [7:0] mask;
        logic       inta_n;
        logic       eoi;
        logic       aeoi;
        logic [4:0] base;
        logic       exp_int;
        logic       exp_freeze;
        logic [7:0] exp_clear;
        logic [7:0] exp_isr;
        logic [7:0] exp_data;
        logic       exp_enable;
    } vector_t;

    vector_t table_vectors[$];

    // Reference model state: progress through the acknowledge is counted in INTA edges.
    int         m_edges;
    logic       m_prev_inta;
    int         m_level;
    logic       m_spurious;
    vector_t    m_exp;

    always #5 clock = ~clock;

    interrupt_acknowledge_sequencer #(.SPURIOUS_LEVEL(7)) dut (
        .clock                              (clock),
        .write_initial_command_word_1_reset (rst),
        .interrupt_request_register         (irr),
        .interrupt_mask                     (mask),
        .interrupt_acknowledge_n            (inta_n),
        .end_of_interrupt                   (eoi),
        .auto_eoi_config                    (aeoi),
        .vector_base                        (base),
        .interrupt_to_cpu                   (int_cpu),
        .freeze                             (freeze),
        .clear_interrupt_request            (clear_req),
        .in_service_register                (isr),
        .data_bus_out                       (data_out),
        .data_bus_out_enable                (data_en)
    );

    function automatic vector_t mk(input logic [7:0] r, input logic [7:0] m, input logic i,
                                   input logic e, input logic a, input logic xi, input logic xf,
                                   input logic [7:0] xc, input logic [7:0] xs,
                                   input logic [7:0] xd, input logic xe);
        vector_t v;
        v.irr = r; v.mask = m; v.inta_n = i; v.eoi = e; v.aeoi = a; v.base = 5'b00001;
        v.exp_int = xi; v.exp_freeze = xf; v.exp_clear = xc;
        v.exp_isr = xs; v.exp_data = xd; v.exp_enable = xe;
        return v;
    endfunction

    function automatic int lowest_index(input logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            if (v[i]) return i;
        end
        return 8;
    endfunction

    task automatic applyStimulus(input vector_t v);
        @(negedge clock);
        irr = v.irr; mask = v.mask; inta_n = v.inta_n;
        eoi = v.eoi; aeoi = v.aeoi; base = v.base;
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input vector_t v);
        assertions++;
        if ({int_cpu, freeze, clear_req, isr, data_out, data_en} !==
            {v.exp_int, v.exp_freeze, v.exp_clear, v.exp_isr, v.exp_data, v.exp_enable}) begin
            failures++;
            $display("[TB] FAIL %s: got int=%0b freeze=%0b clear=%02h isr=%02h data=%02h en=%0b, expected int=%0b freeze=%0b clear=%02h isr=%02h data=%02h en=%0b",
                     name, int_cpu, freeze, clear_req, isr, data_out, data_en,
                     v.exp_int, v.exp_freeze, v.exp_clear, v.exp_isr, v.exp_data, v.exp_enable);
        end
    endtask

    task automatic runRow(input string name, input vector_t v);
        applyStimulus(v);
        checkOutput(name, v);
    endtask

    // One clock of the behavioural model, evaluated on the inputs about to be sampled.
    task automatic modelStep();
        logic       fall, rise;
        int         p, s;
        logic [7:0] new_isr;
        fall = m_prev_inta && !inta_n;
        rise = !m_prev_inta && inta_n;
        p = lowest_index(irr & ~mask);
        s = lowest_index(m_exp.exp_isr);
        new_isr = m_exp.exp_isr;
        if (eoi && s < 8) new_isr = new_isr & ~8'(1 << s);
        m_exp.exp_clear = 8'h00;
        m_exp.exp_int   = 1'b0;
        if (m_edges == 0) begin
            if (fall) begin
                m_edges = 1;
                m_spurious = (p == 8);
                m_level = m_spurious ? 7 : p;
                m_exp.exp_freeze = 1'b1;
                if (!m_spurious) begin
                    m_exp.exp_clear = 8'(1 << p);
                    new_isr = new_isr | 8'(1 << p);
                end
            end else begin
                m_exp.exp_int = (p < s);
            end
        end else if (m_edges == 1) begin
            if (rise) m_edges = 2;
        end else if (m_edges == 2) begin
            if (fall) begin
                m_edges = 3;
                m_exp.exp_data   = 8'(int'(base) * 8 + m_level);
                m_exp.exp_enable = 1'b1;
            end
        end else begin
            if (rise) begin
                m_edges = 0;
                m_exp.exp_data   = 8'h00;
                m_exp.exp_enable = 1'b0;
                m_exp.exp_freeze = 1'b0;
                if (aeoi && !m_spurious) new_isr = new_isr & ~8'(1 << m_level);
            end
        end
        m_exp.exp_isr = new_isr;
        m_prev_inta = inta_n;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vector_t zero;
        rst = 1'b1; irr = 8'h00; mask = 8'h00; inta_n = 1'b1;
        eoi = 1'b0; aeoi = 1'b0; base = 5'b00001;
        zero = mk(8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);

        repeat (2) @(posedge clock);
        #1;
        checkOutput("reset_state", zero);
        @(negedge clock);
        rst = 1'b0;

        // Directed test plan, one row per clock: irr, mask, inta_n, eoi, aeoi -> int, freeze, clear, isr, data, enable
        table_vectors.push_back(mk(8'h28, 8'h00, 1, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 0));
        table_vectors.push_back(mk(8'h28, 8'h00, 0, 0, 0, 0, 1, 8'h08, 8'h08, 8'h00, 0));
        table_vectors.push_back(mk(8'h20, 8'h00, 0, 0, 0, 0, 1, 8'h00, 8'h08, 8'h00, 0));
        table_vectors.push_back(mk(8'h20, 8'h00, 1, 0, 0, 0, 1, 8'h00, 8'h08, 8'h00, 0));
        table_vectors.push_back(mk(8'h20, 8'h00, 1, 0, 0, 0, 1, 8'h00, 8'h08, 8'h00, 0));
        table_vectors.push_back(mk(8'h20, 8'h00, 0, 0, 0, 0, 1, 8'h00, 8'h08, 8'h0B, 1));
        table_vectors.push_back(mk(8'h20, 8'h00, 0, 0, 0, 0, 1, 8'h00, 8'h08, 8'h0B, 1));
        table_vectors.push_back(mk(8'h20, 8'h00, 1, 0, 0, 0, 0, 8'h00, 8'h08, 8'h00, 0));
        table_vectors.push_back(mk(8'h20, 8'h00, 1, 0, 0, 0, 0, 8'h00, 8'h08, 8'h00, 0));
        table_vectors.push_back(mk(8'h04, 8'h00, 1, 0, 0, 1, 0, 8'h00, 8'h08, 8'h00, 0));
        table_vectors.push_back(mk(8'h04, 8'h00, 0, 0, 0, 0, 1, 8'h04, 8'h0C, 8'h00, 0));
        table_vectors.push_back(mk(8'h00, 8'h00, 1, 0, 0, 0, 1, 8'h00, 8'h0C, 8'h00, 0));
        table_vectors.push_back(mk(8'h00, 8'h00, 0, 0, 0, 0, 1, 8'h00, 8'h0C, 8'h0A, 1));
        table_vectors.push_back(mk(8'h00, 8'h00, 1, 0, 0, 0, 0, 8'h00, 8'h0C, 8'h00, 0));
        table_vectors.push_back(mk(8'h00, 8'h00, 1, 1, 0, 0, 0, 8'h00, 8'h08, 8'h00, 0));
        table_vectors.push_back(mk(8'h00, 8'h00, 1, 0, 0, 0, 0, 8'h00, 8'h08, 8'h00, 0));
        table_vectors.push_back(mk(8'h00, 8'h00, 1, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0));
        table_vectors.push_back(mk(8'h00, 8'h00, 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0));
        table_vectors.push_back(mk(8'h80, 8'h00, 1, 0, 1, 1, 0, 8'h00, 8'h00, 8'h00, 0));
        table_vectors.push_back(mk(8'h80, 8'h00, 0, 0, 1, 0, 1, 8'h80, 8'h80, 8'h00, 0));
        table_vectors.push_back(mk(8'h00, 8'h00, 1, 0, 1, 0, 1, 8'h00, 8'h80, 8'h00, 0));
        table_vectors.push_back(mk(8'h00, 8'h00, 0, 0, 1, 0, 1, 8'h00, 8'h80, 8'h0F, 1));
        table_vectors.push_back(mk(8'h00, 8'h00, 1, 0, 1, 0, 0, 8'h00, 8'h00, 8'h00, 0));
        table_vectors.push_back(mk(8'h02, 8'h00, 1, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 0));
        table_vectors.push_back(mk(8'h00, 8'h00, 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0));
        table_vectors.push_back(mk(8'h00, 8'h00, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h00, 0));
        table_vectors.push_back(mk(8'h00, 8'h00, 1, 0, 0, 0, 1, 8'h00, 8'h00, 8'h00, 0));
        table_vectors.push_back(mk(8'h00, 8'h00, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h0F, 1));
        table_vectors.push_back(mk(8'h00, 8'h00, 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0));
        table_vectors.push_back(mk(8'hFF, 8'hFF, 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0));
        table_vectors.push_back(mk(8'hFF, 8'hFF, 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0));

        foreach (table_vectors[i]) begin
            runRow($sformatf("table_row%0d", i), table_vectors[i]);
        end

        // EOI arriving with the first-INTA set: old lowest ISR bit clears, new bit sets.
        runRow("eoi_prep_int",   mk(8'h02, 8'h00, 1, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 0));
        runRow("eoi_prep_ack1",  mk(8'h02, 8'h00, 0, 0, 0, 0, 1, 8'h02, 8'h02, 8'h00, 0));
        runRow("eoi_prep_wait2", mk(8'h00, 8'h00, 1, 0, 0, 0, 1, 8'h00, 8'h02, 8'h00, 0));
        runRow("eoi_prep_ack2",  mk(8'h00, 8'h00, 0, 0, 0, 0, 1, 8'h00, 8'h02, 8'h09, 1));
        runRow("eoi_prep_idle",  mk(8'h00, 8'h00, 1, 0, 0, 0, 0, 8'h00, 8'h02, 8'h00, 0));
        runRow("eoi_nested_int", mk(8'h01, 8'h00, 1, 0, 0, 1, 0, 8'h00, 8'h02, 8'h00, 0));
        runRow("eoi_with_set",   mk(8'h01, 8'h00, 0, 1, 0, 0, 1, 8'h01, 8'h01, 8'h00, 0));
        runRow("eoi_set_wait2",  mk(8'h00, 8'h00, 1, 0, 0, 0, 1, 8'h00, 8'h01, 8'h00, 0));
        runRow("eoi_set_ack2",   mk(8'h00, 8'h00, 0, 0, 0, 0, 1, 8'h00, 8'h01, 8'h08, 1));
        runRow("eoi_set_idle",   mk(8'h00, 8'h00, 1, 0, 0, 0, 0, 8'h00, 8'h01, 8'h00, 0));
        runRow("int_rejected",   mk(8'h01, 8'h00, 1, 0, 0, 0, 0, 8'h00, 8'h01, 8'h00, 0));
        runRow("eoi_same_bit",   mk(8'h01, 8'h00, 0, 1, 0, 0, 1, 8'h01, 8'h01, 8'h00, 0));
        runRow("same_wait2",     mk(8'h00, 8'h00, 1, 0, 0, 0, 1, 8'h00, 8'h01, 8'h00, 0));
        runRow("same_ack2",      mk(8'h00, 8'h00, 0, 0, 0, 0, 1, 8'h00, 8'h01, 8'h08, 1));
        runRow("same_idle",      mk(8'h00, 8'h00, 1, 0, 0, 0, 0, 8'h00, 8'h01, 8'h00, 0));
        runRow("eoi_final",      mk(8'h00, 8'h00, 1, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0));

        // Reset asserted while the vector is being driven, then a fresh sequence.
        runRow("rst_seq_int",    mk(8'h10, 8'h00, 1, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 0));
        runRow("rst_seq_ack1",   mk(8'h10, 8'h00, 0, 0, 0, 0, 1, 8'h10, 8'h10, 8'h00, 0));
        runRow("rst_seq_wait2",  mk(8'h00, 8'h00, 1, 0, 0, 0, 1, 8'h00, 8'h10, 8'h00, 0));
        runRow("ack2_vector",    mk(8'h00, 8'h00, 0, 0, 0, 0, 1, 8'h00, 8'h10, 8'h0C, 1));
        @(negedge clock);
        rst = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("reset_mid_ack2", zero);
        @(negedge clock);
        inta_n = 1'b1; irr = 8'h10; rst = 1'b0;
        @(posedge clock);
        #1;
        checkOutput("post_reset_int", mk(8'h10, 8'h00, 1, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 0));
        runRow("post_reset_ack1",  mk(8'h10, 8'h00, 0, 0, 0, 0, 1, 8'h10, 8'h10, 8'h00, 0));
        runRow("post_reset_wait2", mk(8'h00, 8'h00, 1, 0, 0, 0, 1, 8'h00, 8'h10, 8'h00, 0));
        runRow("post_reset_ack2",  mk(8'h00, 8'h00, 0, 0, 0, 0, 1, 8'h00, 8'h10, 8'h0C, 1));
        runRow("post_reset_idle",  mk(8'h00, 8'h00, 1, 0, 0, 0, 0, 8'h00, 8'h10, 8'h00, 0));

        // Random traffic against the behavioural model.
        @(negedge clock);
        rst = 1'b1; irr = 8'h00; mask = 8'h00; inta_n = 1'b1; eoi = 1'b0; aeoi = 1'b0;
        @(negedge clock);
        rst = 1'b0;
        m_edges = 0; m_prev_inta = 1'b1; m_level = 0; m_spurious = 1'b0;
        m_exp = zero;
        for (int cycle = 0; cycle < 3000; cycle++) begin
            @(negedge clock);
            if ($urandom_range(0, 2) == 0) inta_n = ~inta_n;
            if ($urandom_range(0, 5) == 0) irr = 8'($urandom) & 8'($urandom);
            if ($urandom_range(0, 39) == 0) mask = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            if ($urandom_range(0, 99) == 0) aeoi = ~aeoi;
            if ($urandom_range(0, 49) == 0) base = 5'($urandom);
            eoi = ($urandom_range(0, 9) == 0);
            modelStep();
            @(posedge clock);
            #1;
            checkOutput($sformatf("random_cycle%0d", cycle), m_exp);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
